// File: rtl/data_mem_arbiter.sv
// Two-requester (CPU / host) arbiter for the single-port data memory.
// Round-robin on contention, one access per two cycles, 2-cycle access latency.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_resp,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {CPU, HOST} requester_t;

    state_t     state, state_nxt;
    requester_t owner, owner_nxt;
    requester_t last_grant, last_grant_nxt;
    logic       owner_we, owner_we_nxt;
    logic       pick_host;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            owner      <= CPU;
            last_grant <= HOST;
            owner_we   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            owner_we   <= owner_we_nxt;
        end
    end

    always_comb begin
        // NOTE: every output and next-state term gets a default first, so no
        // path through the case statement can infer a latch.
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        owner_we_nxt   = owner_we;
        pick_host      = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        host_ready     = 1'b0;
        cpu_ack        = 1'b0;
        cpu_rdata      = '0;
        host_resp      = 1'b0;
        host_rdata     = '0;

        case (state)
            IDLE: begin
                // Outputs are held quiet while reset is applied.
                if (!rst && (cpu_req || host_valid)) begin
                    pick_host = host_valid && (!cpu_req || last_grant == CPU);
                    mem_en    = 1'b1;
                    if (pick_host) begin
                        mem_we         = host_we;
                        mem_addr       = host_addr;
                        mem_wdata      = host_wdata;
                        host_ready     = 1'b1;
                        owner_nxt      = HOST;
                        last_grant_nxt = HOST;
                        owner_we_nxt   = host_we;
                    end else begin
                        mem_we         = cpu_we;
                        mem_addr       = cpu_addr;
                        mem_wdata      = cpu_wdata;
                        owner_nxt      = CPU;
                        last_grant_nxt = CPU;
                        owner_we_nxt   = cpu_we;
                    end
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = IDLE;
                // A reset landing here drops the completion pulse entirely.
                if (!rst) begin
                    if (owner == CPU) begin
                        cpu_ack   = 1'b1;
                        cpu_rdata = mem_rdata;
                    end else begin
                        host_resp  = 1'b1;
                        host_rdata = mem_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        cpu_stall = cpu_req & ~cpu_ack;
    end

    // A completing write never overlaps a new write strobe.
    always_comb begin
        if (state == WAIT) begin
            assert (!(owner_we && mem_we));
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter for the single-port data memory, sitting between the CPU datapath and the memory array. Requesters are the CPU load/store path and a host/debug port used for program inspection and test-data loading. The block grants one access at a time and alternates between requesters on contention. It stalls the CPU while its access is pending and returns read data with fixed 2-cycle access latency.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width (passed through unmodified)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU requests a memory access (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_WIDTH  CPU access address (ALU result)
- cpu_wdata  in  DATA_WIDTH  CPU store data (register file RD2)
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- cpu_stall  out  1  freeze PC/register write-back while CPU access pending
- host_valid  in  1  host presents a request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_ready  out  1  request accepted this cycle (valid & ready = handshake)
- host_resp  out  1  one-cycle pulse: host access complete
- host_rdata  out  DATA_WIDTH  read data, valid when host_resp=1 and the access was a read
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (qualified by mem_en)
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, registered; valid the cycle after mem_en

## Operation
- FSM states: IDLE, WAIT. Registered: state, owner (CPU/HOST), last_grant (CPU/HOST), owner_we.
- IDLE:
  - No request: mem_en=0, stay in IDLE.
  - Only one requester active: grant it.
  - Both active: grant the requester that is not last_grant (round-robin).
  - On grant: mem_en=1; mem_we/addr/wdata driven combinationally from the winner. host_ready=1 if the host wins. Register owner, owner_we and last_grant; go to WAIT.
- WAIT:
  - mem_en=0.
  - owner=CPU: cpu_ack=1, cpu_rdata=mem_rdata.
  - owner=HOST: host_resp=1, host_rdata=mem_rdata.
  - Always return to IDLE. There is no back-to-back issue, so peak throughput is one access per 2 cycles.
- cpu_stall = cpu_req & ~cpu_ack (combinational).
- The CPU holds cpu_req/we/addr/wdata stable until cpu_ack. The host may drop or change its request only after the host_ready handshake.
- Write data is not returned. cpu_rdata/host_rdata on a write completion are don't-care, but must equal mem_rdata.
- Outputs not being asserted read 0: cpu_rdata=0 when cpu_ack=0, host_rdata=0 when host_resp=0.

## Timing
- Reset (rst=1 at an edge): state=IDLE, last_grant=HOST (so the CPU wins the first contention), owner=CPU.
- Reset output values: cpu_ack=0, host_resp=0, host_ready=0, mem_en=0, mem_we=0, cpu_rdata=0, host_rdata=0. cpu_stall follows cpu_req.
- Reset in WAIT aborts the completion: no ack/resp pulse is issued. A write already strobed stays in memory.
- Latency: request seen in IDLE at cycle N → mem_en at N → ack/resp at N+1. The CPU therefore stalls exactly 1 cycle when uncontended.
- Contention worst case for the CPU: host granted at N, CPU granted at N+2, cpu_ack at N+3, giving 3 stall cycles.
- A request arriving while in WAIT is not sampled until the following IDLE cycle.
- Neither requester can be starved: under continuous requests from both, grants alternate strictly.

## Test plan
- Reset then idle: rst=1 two cycles, no requests → mem_en=0, all acks 0, and they stay 0 for 5 cycles after release.
- CPU store then load: cpu_req, we=1, addr=0x10, wdata=0xDEADBEEF → mem_en/mem_we at N, cpu_ack at N+1, stall high only at N. Then a load from 0x10 → cpu_rdata=0xDEADBEEF with cpu_ack.
- Simultaneous first contention: cpu_req and host_valid both asserted right after reset → CPU granted first (cpu_ack at N+1), host_ready at N+2, host_resp at N+3.
- Sustained contention: both request continuously for 8 grants → grant order alternates CPU,HOST,CPU,…, and no requester gets two consecutive grants.
- Host read handshake: host_valid with addr=0x20 (preloaded 0x12345678), no CPU activity → host_ready at N, host_resp at N+1 with host_rdata=0x12345678.
- Reset mid-access: rst asserted during WAIT of a CPU load → no cpu_ack the next cycle, state=IDLE, and the next contention grants the CPU.
